mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one fixed-latency memory port between two requesters (port 0: multi_cycle_mips core,
//  port 1: DMA/loader or second core). Requesters use a req/ack handshake; the arbiter sequences
//  MAR/MRE/MWE-style strobes toward memory. By default it arbitrates round-robin. It sits between
//  the masters and the memory model.
// PARAMETERS
//  AW       32  address width
//  DW       32  data width
//  MEM_LAT  3   cycles mem_read/mem_write held before data is valid or the write completes (>=1)
// PORTS
//  clk             in   1   clock, all state on posedge
//  reset           in   1   asynchronous, active-high; clears all state immediately
//  req0/req1       in   1   request, held high until ack seen
//  we0/we1         in   1   1=write 0=read, stable while req high
//  addr0/addr1     in   AW  address, stable while req high
//  wdata0/wdata1   in   DW  write data, stable while req high
//  ack0/ack1       out  1   one-cycle completion pulse
//  rdata0/rdata1   out  DW  registered read data, valid in ack cycle, held until next read on same port
//  mem_addr        out  AW  to memory (registered)
//  mem_write_data  out  DW  to memory (registered)
//  mem_read        out  1   read strobe (registered)
//  mem_write       out  1   write strobe (registered)
//  mem_read_data   in   DW  from memory, valid after MEM_LAT strobe cycles
//  busy            out  1   high in BUSY/ACK
//  owner           out  1   port owning current/last transaction
// BEHAVIOUR
//  Reset values: all outputs 0; state=IDLE; cnt=0; last_grant=1, so port 0 wins the first tie.
//  FSM: IDLE -> BUSY -> ACK -> IDLE.
//  IDLE:
//   - No req: stay in IDLE.
//   - Any req: pick winner W.
//     - One req: that port.
//     - Both reqs: port != last_grant.
//   - On the edge: latch mem_addr/mem_write_data from W.
//   - Set mem_read=~weW or mem_write=weW; owner=W; cnt=MEM_LAT-1; go to BUSY.
//  BUSY:
//   - Strobe held; cnt decrements each cycle.
//   - When cnt==0: if read, capture mem_read_data into rdataW.
//   - Clear strobes; go to ACK.
//  ACK:
//   - ackW=1 for exactly this cycle; last_grant=W; go to IDLE.
//   - No new grant in ACK.
//  Timing:
//   - Strobe high exactly MEM_LAT cycles.
//   - ack asserted MEM_LAT+1 cycles after the IDLE cycle that sampled req.
//   - Max throughput: one transaction per MEM_LAT+2 cycles.
//  Requester rule: drop req (or present the next request) on the edge where ack is sampled.
//   A req still high in IDLE is a new request.
//  Loser's req is untouched and wins the next IDLE arbitration (round-robin gives no starvation).
//  req deasserted mid-transaction: protocol violation; transaction still completes and ack pulses.
//  Write: rdataW unchanged.
//  Async reset mid-transaction: strobes and acks drop at once, transaction is lost, FSM returns to IDLE.
//  Widths: cnt is $clog2(MEM_LAT+1) bits and never wraps; MEM_LAT=1 gives one BUSY cycle.
// CONFIGURATION
//  MEM_ARB_FIXED_PRIO_EN defined: port 0 always wins simultaneous requests; last_grant is ignored.
//   Port 1 may starve.
//  Undefined (default): round-robin as above.
// TESTING
//  1 Reset, then req0 read addr=0x10 with mem returning 0xDEADBEEF:
//    mem_read high 3 cycles; ack0 on cycle 4 after grant; rdata0=0xDEADBEEF.
//  2 req1 write addr=0x20 wdata=0x12345678:
//    mem_write high 3 cycles, mem_addr=0x20, mem_write_data=0x12345678; ack1 pulses once; rdata1 unchanged.
//  3 req0 and req1 both held continuously after reset:
//    grants alternate 0,1,0,1; one ack every 5 cycles (MEM_LAT=3).
//    With MEM_ARB_FIXED_PRIO_EN: only ack0 pulses.
//  4 req1 raised while port 0 is in BUSY: port 0 completes unaffected; port 1 granted in the next IDLE.
//  5 reset asserted in the 2nd BUSY cycle: mem_read, ack0 and ack1 go 0 without waiting for clk.
//    After release, a fresh req0 completes normally.
//  6 MEM_LAT=1 build, single read: mem_read high 1 cycle; ack0 two cycles after grant.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one fixed-latency memory port between two requesters. Port 0 is
// normally the multi-cycle core, port 1 a DMA/loader or a second core. Each
// requester raises req with we/addr/wdata stable and holds it until it sees a
// one-cycle ack pulse. The arbiter owns the memory strobes (mem_read or
// mem_write), which stay high for exactly MEM_LAT cycles. On a read it
// captures mem_read_data into that port's rdata register in the last strobe
// cycle.
//
// Sequence per transaction: IDLE (sample req) -> BUSY (MEM_LAT cycles of
// strobe) -> ACK (one cycle) -> IDLE. The arbiter is busy for MEM_LAT+2
// cycles per transaction, including the IDLE sampling cycle.
//
// Configuration macro:
//   MEM_ARB_FIXED_PRIO_EN  when defined, port 0 always wins simultaneous
//                          requests and port 1 may starve. When undefined
//                          (the default), simultaneous requests alternate
//                          round-robin, and port 0 wins the first tie after
//                          reset.
//
// Parameters:
//   AW       address width
//   DW       data width
//   MEM_LAT  strobe cycles before read data is valid or a write completes (>=1)
//
// Ports:
//   clk             clock, all state on posedge
//   reset           asynchronous active-high reset
//   req0/req1       request, held until ack
//   we0/we1         1 = write, 0 = read
//   addr0/addr1     request address
//   wdata0/wdata1   request write data
//   ack0/ack1       one-cycle completion pulse
//   rdata0/rdata1   read data, valid in ack cycle, held until next read
//   mem_addr        registered memory address
//   mem_write_data  registered memory write data
//   mem_read        registered read strobe
//   mem_write       registered write strobe
//   mem_read_data   data returned by memory
//   busy            high while a transaction is in BUSY or ACK
//   owner           port owning the current or last transaction
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_write_data,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_read_data,
    output logic          busy,
    output logic          owner
);

    // Counter just wide enough to hold MEM_LAT-1; it only counts down to zero.
    localparam int CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_owner;
    logic            r_busy;
    logic            r_ack0;
    logic            r_ack1;
    logic [DW-1:0]   r_rdata0;
    logic [DW-1:0]   r_rdata1;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic            r_mem_read;
    logic            r_mem_write;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic            r_last_grant;
`endif

    logic            w_any_req;
    logic            w_winner;
    logic            w_sel_we;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_wdata;

    // Arbitration: pick the port to serve if the FSM is in IDLE.
    always_comb begin
        w_any_req = req0 | req1;
        w_winner  = 1'b0;
        if (req0 && req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            w_winner = 1'b0;
`else
            // The port that did not win the previous transaction goes next.
            w_winner = ~r_last_grant;
`endif
        end else if (req1) begin
            w_winner = 1'b1;
        end else begin
            w_winner = 1'b0;
        end
    end

    // Request mux: route the winning port's command toward the memory registers.
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = addr0;
        w_sel_wdata = wdata0;
        if (w_winner) begin
            w_sel_we    = we1;
            w_sel_addr  = addr1;
            w_sel_wdata = wdata1;
        end else begin
            w_sel_we    = we0;
            w_sel_addr  = addr0;
            w_sel_wdata = wdata0;
        end
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= CNT_ZERO;
            r_owner      <= 1'b0;
            r_busy       <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_rdata0     <= {DW{1'b0}};
            r_rdata1     <= {DW{1'b0}};
            r_mem_addr   <= {AW{1'b0}};
            r_mem_wdata  <= {DW{1'b0}};
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            // Port 0 wins the first tie after reset.
            r_last_grant <= 1'b1;
`endif
        end else begin
            // Acks are single-cycle pulses; only the BUSY->ACK edge sets one.
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_mem_read  <= ~w_sel_we;
                        r_mem_write <= w_sel_we;
                        r_owner     <= w_winner;
                        r_cnt       <= CNT_LOAD;
                        r_busy      <= 1'b1;
                        r_state     <= ST_BUSY;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == CNT_ZERO) begin
                        // Last strobe cycle: memory data is valid now.
                        if (r_mem_read) begin
                            if (r_owner) begin
                                r_rdata1 <= mem_read_data;
                            end else begin
                                r_rdata0 <= mem_read_data;
                            end
                        end else begin
                            r_rdata0 <= r_rdata0;
                        end
                        if (r_owner) begin
                            r_ack1 <= 1'b1;
                        end else begin
                            r_ack0 <= 1'b1;
                        end
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_state     <= ST_ACK;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_ACK: begin
                    // No grant here: a req still high is sampled in the next IDLE.
`ifndef MEM_ARB_FIXED_PRIO_EN
                    r_last_grant <= r_owner;
`endif
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    // Unreachable encoding: park safely with strobes off.
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack0           = r_ack0;
    assign ack1           = r_ack1;
    assign rdata0         = r_rdata0;
    assign rdata1         = r_rdata1;
    assign mem_addr       = r_mem_addr;
    assign mem_write_data = r_mem_wdata;
    assign mem_read       = r_mem_read;
    assign mem_write      = r_mem_write;
    assign busy           = r_busy;
    assign owner          = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int LAT = 3;
`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        t_req   [2];
    logic        t_we    [2];
    logic [31:0] t_addr  [2];
    logic [31:0] t_wdata [2];
    logic        ack0, ack1, mem_read, mem_write, busy, owner;
    logic [31:0] rdata0, rdata1, mem_addr, mem_write_data, mem_read_data;

    // Second instance built with MEM_LAT=1; only port 0 is exercised.
    logic        b_req0, b_we0, b_ack0, b_ack1, b_mem_read, b_mem_write, b_busy, b_owner;
    logic [31:0] b_addr0, b_wdata0, b_rdata0, b_rdata1, b_mem_addr, b_mem_wdata, b_mem_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .req0(t_req[0]), .req1(t_req[1]), .we0(t_we[0]), .we1(t_we[1]),
        .addr0(t_addr[0]), .addr1(t_addr[1]), .wdata0(t_wdata[0]), .wdata1(t_wdata[1]),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data),
        .busy(busy), .owner(owner)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_dut_lat1 (
        .clk(clk), .reset(reset),
        .req0(b_req0), .req1(1'b0), .we0(b_we0), .we1(1'b0),
        .addr0(b_addr0), .addr1(32'h0), .wdata0(b_wdata0), .wdata1(32'h0),
        .ack0(b_ack0), .ack1(b_ack1), .rdata0(b_rdata0), .rdata1(b_rdata1),
        .mem_addr(b_mem_addr), .mem_write_data(b_mem_wdata),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_read_data(b_mem_rdata),
        .busy(b_busy), .owner(b_owner)
    );

    // Environment memory: 64 words, combinational read, write on strobe edges.
    logic [31:0] mem_arr [64];
    logic        env_init, pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_data;

    function automatic logic [31:0] init_word(input int i);
        return 32'h5A000000 ^ (32'(i) * 32'h00010203);
    endfunction

    assign mem_read_data = mem_arr[mem_addr[7:2]];

    always @(posedge clk) begin
        if (env_init) begin
            for (int i = 0; i < 64; i++) mem_arr[i] <= init_word(i);
        end else if (pl_en) begin
            mem_arr[pl_idx] <= pl_data;
        end else if (mem_write) begin
            mem_arr[mem_addr[7:2]] <= mem_write_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int p = 0; p < 2; p++) t_req[p] = 1'b0;
        b_req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_idx = a[7:2]; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        preload;
        logic [31:0] mem_word;
        logic [31:0] exp_rdata0;
        logic [31:0] exp_rdata1;
    } vec_t;

    vec_t vecs [7];

    // Reference model state for the randomized phase.
    bit          tx_valid;
    int          tx_g, tx_port, last_w, owner_exp, w;
    logic        tx_we;
    logic [31:0] tx_addr, tx_wdata;
    logic [31:0] shadow [64];
    logic [31:0] exp_rd [2];
    logic        in_str, in_busy, ack_cyc, acked;

    int n_str, lat, n_ack, p, acks_seen, last_ack_c, a0, a1;
    vec_t cv;

    task automatic new_req(input int q);
        t_we[q]    = 1'($urandom_range(1, 0));
        t_addr[q]  = {24'h0, 6'($urandom_range(63, 0)), 2'b00};
        t_wdata[q] = $urandom;
        t_req[q]   = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // {port, we, addr, wdata, preload, mem_word, exp_rdata0, exp_rdata1}
        vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 32'h0,        32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h24, 32'h0,        1'b1, 32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D};
        vecs[3] = '{1'b0, 1'b1, 32'h30, 32'hA5A5A5A5, 1'b0, 32'h0,        32'hDEADBEEF, 32'hCAFEF00D};
        vecs[4] = '{1'b0, 1'b0, 32'h20, 32'h0,        1'b0, 32'h0,        32'h12345678, 32'hCAFEF00D};
        vecs[5] = '{1'b1, 1'b1, 32'h24, 32'h0F0F0F0F, 1'b0, 32'h0,        32'h12345678, 32'hCAFEF00D};
        vecs[6] = '{1'b1, 1'b0, 32'h24, 32'h0,        1'b0, 32'h0,        32'h12345678, 32'h0F0F0F0F};

        reset = 1'b1; env_init = 1'b0; pl_en = 1'b0; pl_idx = 6'd0; pl_data = 32'h0;
        for (int q = 0; q < 2; q++) begin
            t_req[q] = 1'b0; t_we[q] = 1'b0; t_addr[q] = 32'h0; t_wdata[q] = 32'h0;
        end
        b_req0 = 1'b0; b_we0 = 1'b0; b_addr0 = 32'h0; b_wdata0 = 32'h0; b_mem_rdata = 32'h0;

        // Reset values
        @(negedge clk); @(negedge clk);
        check("rst_ack", {30'h0, ack1, ack0}, 32'h0);
        check("rst_strobes", {30'h0, mem_write, mem_read}, 32'h0);
        check("rst_busy_owner", {30'h0, busy, owner}, 32'h0);
        check("rst_rdata0", rdata0, 32'h0);
        check("rst_rdata1", rdata1, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_write_data, 32'h0);
        check("rst_lat1_outs", {25'h0, b_ack0, b_ack1, b_mem_read, b_mem_write, b_busy, b_owner, 1'b0}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven single transactions
        for (int v = 0; v < 7; v++) begin
            cv = vecs[v];
            if (cv.preload) preload(cv.addr, cv.mem_word);
            p = int'(cv.port);
            t_we[p] = cv.we; t_addr[p] = cv.addr; t_wdata[p] = cv.wdata; t_req[p] = 1'b1;
            n_str = 0; lat = 0; n_ack = 0;
            for (int c = 1; c <= 12; c++) begin
                @(negedge clk);
                if (mem_read || mem_write) begin
                    n_str++;
                    check("vec_strobe_kind", {30'h0, mem_write, mem_read}, cv.we ? 32'h2 : 32'h1);
                    check("vec_mem_addr", mem_addr, cv.addr);
                    if (cv.we) check("vec_mem_wdata", mem_write_data, cv.wdata);
                end
                if (ack0 || ack1) begin
                    n_ack++;
                    if (lat == 0) begin
                        lat = c;
                        check("vec_ack_port", {30'h0, ack1, ack0}, cv.port ? 32'h2 : 32'h1);
                        check("vec_rdata0", rdata0, cv.exp_rdata0);
                        check("vec_rdata1", rdata1, cv.exp_rdata1);
                        check("vec_owner", owner, cv.port);
                        t_req[p] = 1'b0;
                    end
                end
            end
            check("vec_strobe_cycles", n_str, LAT);
            check("vec_ack_latency", lat, LAT + 1);
            check("vec_ack_count", n_ack, 1);
            check("vec_rdata0_held", rdata0, cv.exp_rdata0);
            check("vec_rdata1_held", rdata1, cv.exp_rdata1);
        end

        // Both ports requesting continuously after reset
        do_reset();
        t_we[0] = 1'b0; t_addr[0] = 32'h40; t_we[1] = 1'b0; t_addr[1] = 32'h44;
        t_req[0] = 1'b1; t_req[1] = 1'b1;
        acks_seen = 0; last_ack_c = 0;
        for (int c = 1; c <= 24 && acks_seen < 4; c++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                check("tie_ack_order", {30'h0, ack1, ack0},
                      (FIXED || (acks_seen % 2 == 0)) ? 32'h1 : 32'h2);
                if (acks_seen > 0) check("tie_ack_spacing", c - last_ack_c, LAT + 2);
                last_ack_c = c;
                acks_seen++;
            end
        end
        check("tie_ack_total", acks_seen, 4);
        t_req[0] = 1'b0; t_req[1] = 1'b0;

        // Port 1 raises its request while port 0 is mid-transaction
        @(negedge clk);
        preload(32'h50, 32'h11112222);
        t_we[0] = 1'b0; t_addr[0] = 32'h50; t_req[0] = 1'b1;
        a0 = 0; a1 = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 3) begin
                check("late_p0_read", mem_read, 1'b1);
                check("late_p0_addr", mem_addr, 32'h50);
            end
            if (c == 7) begin
                check("late_p1_write", mem_write, 1'b1);
                check("late_p1_addr", mem_addr, 32'h54);
                check("late_p1_wdata", mem_write_data, 32'h33334444);
            end
            if (ack0 && a0 == 0) begin
                a0 = c; t_req[0] = 1'b0;
                check("late_p0_rdata", rdata0, 32'h11112222);
            end
            if (ack1 && a1 == 0) begin
                a1 = c; t_req[1] = 1'b0;
            end
            if (c == 2) begin
                t_we[1] = 1'b1; t_addr[1] = 32'h54; t_wdata[1] = 32'h33334444; t_req[1] = 1'b1;
            end
        end
        check("late_ack0_cycle", a0, LAT + 1);
        check("late_ack1_cycle", a1, 2 * LAT + 3);

        // Asynchronous reset during the second BUSY cycle
        @(negedge clk);
        t_we[0] = 1'b0; t_addr[0] = 32'h10; t_req[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("arst_read_before", mem_read, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("arst_mem_read", mem_read, 1'b0);
        check("arst_acks", {30'h0, ack1, ack0}, 32'h0);
        check("arst_busy", busy, 1'b0);
        check("arst_rdata0", rdata0, 32'h0);
        t_req[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        preload(32'h18, 32'h77665544);
        t_addr[0] = 32'h18; t_req[0] = 1'b1;
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (ack0 && lat == 0) begin
                lat = c; t_req[0] = 1'b0;
                check("arst_fresh_rdata", rdata0, 32'h77665544);
            end
        end
        check("arst_fresh_latency", lat, LAT + 1);

        // Randomized traffic against a cycle-count schedule model
        do_reset();
        env_init = 1'b1;
        @(negedge clk);
        env_init = 1'b0;
        for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
        tx_valid = 1'b0; tx_g = 0; tx_port = 0; tx_we = 1'b0; tx_addr = 32'h0; tx_wdata = 32'h0;
        last_w = 1; owner_exp = 0; exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            in_str  = tx_valid && c >= tx_g && c < tx_g + LAT;
            in_busy = tx_valid && c >= tx_g && c <= tx_g + LAT;
            ack_cyc = tx_valid && c == tx_g + LAT;
            if (tx_valid && c == tx_g) owner_exp = tx_port;
            check("rnd_mem_read", mem_read, in_str && !tx_we);
            check("rnd_mem_write", mem_write, in_str && tx_we);
            if (in_str) check("rnd_mem_addr", mem_addr, tx_addr);
            if (in_str && tx_we) check("rnd_mem_wdata", mem_write_data, tx_wdata);
            check("rnd_busy", busy, in_busy);
            check("rnd_ack0", ack0, ack_cyc && tx_port == 0);
            check("rnd_ack1", ack1, ack_cyc && tx_port == 1);
            if (ack_cyc) begin
                if (tx_we) shadow[tx_addr[7:2]] = tx_wdata;
                else exp_rd[tx_port] = shadow[tx_addr[7:2]];
                last_w = tx_port;
            end
            check("rnd_rdata0", rdata0, exp_rd[0]);
            check("rnd_rdata1", rdata1, exp_rd[1]);
            check("rnd_owner", owner, owner_exp);
            // Requesters: hold until ack, then drop or present the next request
            for (int q = 0; q < 2; q++) begin
                acked = ack_cyc && tx_port == q;
                if (t_req[q] && acked) begin
                    if ($urandom_range(1, 0) == 1) new_req(q);
                    else t_req[q] = 1'b0;
                end else if (!t_req[q] && $urandom_range(2, 0) == 0) begin
                    new_req(q);
                end
            end
            // Grant prediction for the coming edge when the arbiter is idle
            if ((!tx_valid || c > tx_g + LAT) && (t_req[0] || t_req[1])) begin
                if (t_req[0] && t_req[1]) w = FIXED ? 0 : 1 - last_w;
                else w = t_req[0] ? 0 : 1;
                tx_valid = 1'b1; tx_g = c + 1; tx_port = w;
                tx_we = t_we[w]; tx_addr = t_addr[w]; tx_wdata = t_wdata[w];
            end
        end
        t_req[0] = 1'b0; t_req[1] = 1'b0;

        // MEM_LAT=1 instance: single read
        @(negedge clk);
        b_mem_rdata = 32'h600DF00D; b_we0 = 1'b0; b_addr0 = 32'h40; b_wdata0 = 32'h13572468; b_req0 = 1'b1;
        n_str = 0; lat = 0; n_ack = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("lat1_busy", b_busy, 1'b1);
                check("lat1_wdata_latched", b_mem_wdata, 32'h13572468);
            end
            if (b_mem_read) begin
                n_str++;
                check("lat1_mem_addr", b_mem_addr, 32'h40);
            end
            check("lat1_no_write", b_mem_write, 1'b0);
            check("lat1_no_ack1", b_ack1, 1'b0);
            if (b_ack0) begin
                n_ack++;
                if (lat == 0) begin
                    lat = c; b_req0 = 1'b0;
                    check("lat1_rdata0", b_rdata0, 32'h600DF00D);
                    check("lat1_owner", b_owner, 1'b0);
                end
            end
        end
        check("lat1_strobe_cycles", n_str, 1);
        check("lat1_ack_latency", lat, 2);
        check("lat1_ack_count", n_ack, 1);
        check("lat1_rdata1", b_rdata1, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
